// File: rtl/nubus_mem_pkg.sv
// Shared types and constants for the NuBus SRAM slave: FSM states, default
// geometry and the address-window range check.
package nubus_mem_pkg;

    localparam int DEF_MEMORY_W  = 14;
    localparam int DEF_WAIT_W    = 3;
    localparam int SLOT_WINDOW_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Slot space only decodes the low 24 address bits; expansion space decodes all 32.
    function automatic logic range_error(input logic [31:0] addr, input logic exp_space,
                                         input int memory_w);
        logic [31:0] window;
        window = exp_space ? addr : (addr & ((32'h1 << SLOT_WINDOW_W) - 32'h1));
        return (window >> (memory_w + 2)) != 32'h0;
    endfunction

endpackage

// File: rtl/nubus_mem_array.sv
// Four byte-lane synchronous RAM with a single read/write port, per-lane write
// enables and a registered read output that can be cleared.
module nubus_mem_array
    import nubus_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_MEMORY_W
) (
    input  logic              mem_clk,
    input  logic              mem_reset,
    input  logic              rd_en,
    input  logic              clr,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] q_reg;

            always_ff @(posedge mem_clk) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
            end

            // Output register keeps its value across writes; only reads or clears move it.
            always_ff @(posedge mem_clk or posedge mem_reset) begin
                if (mem_reset) begin
                    q_reg <= '0;
                end else if (clr) begin
                    q_reg <= '0;
                end else if (rd_en) begin
                    q_reg <= lane_mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/nubus_sram_slave.sv
// NuBus-style SRAM slave: accepts slot/expansion requests, inserts programmable
// wait states, then acknowledges for one cycle and holds until the master lets go.
module nubus_sram_slave
    import nubus_mem_pkg::*;
#(
    parameter int MEMORY_W = DEF_MEMORY_W,
    parameter int WAIT_W   = DEF_WAIT_W
) (
    input  logic              mem_clk,
    input  logic              mem_reset,
    input  logic              mem_valid,
    input  logic [3:0]        mem_write,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_myslot,
    input  logic              mem_myexp,
    input  logic [WAIT_W-1:0] mem_wait_clocks,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_ready_o,
    output logic              mem_error_o,
    output logic              mem_write_o
);

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   cnt_reg, cnt_next;
    logic [MEMORY_W-1:0] idx_reg;
    logic [3:0]          strb_reg;
    logic [31:0]         wdata_reg;
    logic                err_reg;

    logic                accept, in_idle, enter_ack;
    logic [MEMORY_W-1:0] cur_idx;
    logic [3:0]          cur_strb;
    logic [31:0]         cur_wdata;
    logic                cur_err;

    assign in_idle = (state_reg == ST_IDLE);
    assign accept  = in_idle && mem_valid && (mem_myslot || mem_myexp);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = (mem_wait_clocks != '0) ? ST_WAIT : ST_ACK;
            ST_WAIT: begin
                if (!mem_valid) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == WAIT_W'(1)) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_HOLD;
            ST_HOLD: if (!mem_valid) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_next = '0;
        if (state_next == ST_WAIT) begin
            cnt_next = in_idle ? mem_wait_clocks : cnt_reg - WAIT_W'(1);
        end
    end

    // A zero-wait request enters ACK on its acceptance edge, so the array must
    // see the live request then; otherwise it uses the latched copy.
    assign cur_idx   = in_idle ? mem_addr[MEMORY_W+1:2] : idx_reg;
    assign cur_strb  = in_idle ? mem_write : strb_reg;
    assign cur_wdata = in_idle ? mem_wdata : wdata_reg;
    assign cur_err   = in_idle ? range_error(mem_addr, mem_myexp, MEMORY_W) : err_reg;
    assign enter_ack = (state_next == ST_ACK);

    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            strb_reg  <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                idx_reg   <= mem_addr[MEMORY_W+1:2];
                strb_reg  <= mem_write;
                wdata_reg <= mem_wdata;
                err_reg   <= range_error(mem_addr, mem_myexp, MEMORY_W);
            end
        end
    end

    nubus_mem_array #(
        .ADDR_W (MEMORY_W)
    ) u_array (
        .mem_clk   (mem_clk),
        .mem_reset (mem_reset),
        .rd_en     (enter_ack && !cur_err && (cur_strb == 4'b0000)),
        .clr       (enter_ack && cur_err),
        .we        ((enter_ack && !cur_err) ? cur_strb : 4'b0000),
        .addr      (cur_idx),
        .wdata     (cur_wdata),
        .rdata     (mem_rdata_o)
    );

    assign mem_ready_o = (state_reg == ST_ACK);
    assign mem_error_o = mem_ready_o && err_reg;
    assign mem_write_o = |mem_write;

endmodule
